// File: rtl/conv_8x32_pkg.sv
// Shared types and default widths for the conv_8x32 vector-subtract block.
package conv_8x32_pkg;

  typedef enum logic [1:0] {
    WRAP  = 2'd0,
    SAT_U = 2'd1,
    SAT_S = 2'd2,
    ABS_U = 2'd3
  } vsub_mode_e;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_LANES      = 4;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/conv_8x32_vsub_lane.sv
// One combinational subtraction lane: wrap, unsigned/signed saturate, or absolute difference.
module conv_8x32_vsub_lane
  import conv_8x32_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  vsub_mode_e            mode,
  output logic [DATA_WIDTH-1:0] d,
  output logic                  flag
);

  logic [DATA_WIDTH:0] udiff;
  logic [DATA_WIDTH:0] sdiff;
  logic                borrow;
  logic                s_ovf;

  assign udiff  = {1'b0, a} - {1'b0, b};
  assign sdiff  = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
  assign borrow = udiff[DATA_WIDTH];
  // Signed overflow shows up as disagreement between the extra sign bit and the result MSB.
  assign s_ovf  = sdiff[DATA_WIDTH] ^ sdiff[DATA_WIDTH-1];

  always_comb begin
    d    = udiff[DATA_WIDTH-1:0];
    flag = 1'b0;
    unique case (mode)
      WRAP: begin
        flag = borrow;
      end
      SAT_U: begin
        if (borrow) d = '0;
        flag = borrow;
      end
      SAT_S: begin
        d    = sdiff[DATA_WIDTH-1:0];
        flag = s_ovf;
        if (s_ovf) d = {sdiff[DATA_WIDTH], {(DATA_WIDTH-1){~sdiff[DATA_WIDTH]}}};
      end
      ABS_U: begin
        if (borrow) d = '0 - udiff[DATA_WIDTH-1:0];
        flag = borrow;
      end
    endcase
  end

endmodule

// File: rtl/conv_8x32_vsub.sv
// Two-stage elastic lane-parallel subtractor; define CONV_VSUB_STATS_EN to add the flagged-beat counter.
module conv_8x32_vsub
  import conv_8x32_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  mode_in,
  input  logic [LANES*DATA_WIDTH-1:0] a_in,
  input  logic [LANES*DATA_WIDTH-1:0] b_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] d_out,
  output logic [LANES-1:0]            flag_out
`ifdef CONV_VSUB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]        sat_cnt_out,
  input  logic                        stats_clr_in
`endif
);

  logic                        s1_valid;
  logic [LANES*DATA_WIDTH-1:0] s1_a;
  logic [LANES*DATA_WIDTH-1:0] s1_b;
  vsub_mode_e                  s1_mode;
  logic                        s2_load;
  logic [LANES*DATA_WIDTH-1:0] lane_d;
  logic [LANES-1:0]            lane_f;

  // S2 is the output register, so out_valid doubles as the S2 valid bit.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= WRAP;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= a_in;
        s1_b    <= b_in;
        s1_mode <= vsub_mode_e'(mode_in);
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    conv_8x32_vsub_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .a   (s1_a[i*DATA_WIDTH +: DATA_WIDTH]),
      .b   (s1_b[i*DATA_WIDTH +: DATA_WIDTH]),
      .mode(s1_mode),
      .d   (lane_d[i*DATA_WIDTH +: DATA_WIDTH]),
      .flag(lane_f[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      d_out     <= '0;
      flag_out  <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        d_out    <= lane_d;
        flag_out <= lane_f;
      end
    end
  end

`ifdef CONV_VSUB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_out <= '0;
    end else if (stats_clr_in) begin
      sat_cnt_out <= '0;
    end else if (out_valid && out_ready && (|flag_out) && (sat_cnt_out != '1)) begin
      sat_cnt_out <= sat_cnt_out + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_conv_8x32_vsub.sv
// Randomized self-checking bench for conv_8x32_vsub against an arithmetic reference model.
module tb_conv_8x32_vsub;
  import conv_8x32_pkg::*;

  localparam int DW = 8;
  localparam int LN = 4;
  localparam int CW = 16;

  typedef struct packed {
    logic [LN*DW-1:0] d;
    logic [LN-1:0]    f;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       mode_in = 2'd0;
  logic [LN*DW-1:0] a_in = '0;
  logic [LN*DW-1:0] b_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [LN*DW-1:0] d_out;
  logic [LN-1:0]    flag_out;
`ifdef CONV_VSUB_STATS_EN
  logic [CW-1:0]    sat_cnt_out;
  logic             stats_clr_in = 1'b0;
`endif

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t exp_q[$];

  conv_8x32_vsub #(
    .DATA_WIDTH(DW),
    .LANES     (LN),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mode_in     (mode_in),
    .a_in        (a_in),
    .b_in        (b_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .d_out       (d_out),
    .flag_out    (flag_out)
`ifdef CONV_VSUB_STATS_EN
    ,
    .sat_cnt_out (sat_cnt_out),
    .stats_clr_in(stats_clr_in)
`endif
  );

  always #5 clk = ~clk;

  function automatic beat_t model(input logic [1:0] m, input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b);
    beat_t res;
    res = '0;
    for (int i = 0; i < LN; i++) begin
      int ai, bi, df, sa, sb, sd, r;
      logic fl;
      ai = int'(a[i*DW +: DW]);
      bi = int'(b[i*DW +: DW]);
      df = ai - bi;
      r  = df;
      fl = 1'b0;
      case (m)
        2'd0: begin r = df; fl = (ai < bi); end
        2'd1: begin r = (df < 0) ? 0 : df; fl = (df < 0); end
        2'd2: begin
          sa = (ai >= (1 << (DW-1))) ? ai - (1 << DW) : ai;
          sb = (bi >= (1 << (DW-1))) ? bi - (1 << DW) : bi;
          sd = sa - sb;
          if (sd > (1 << (DW-1)) - 1) begin r = (1 << (DW-1)) - 1; fl = 1'b1; end
          else if (sd < -(1 << (DW-1))) begin r = -(1 << (DW-1)); fl = 1'b1; end
          else r = sd;
        end
        default: begin r = (df < 0) ? -df : df; fl = (df < 0); end
      endcase
      res.d[i*DW +: DW] = r[DW-1:0];
      res.f[i] = fl;
    end
    return res;
  endfunction

  function automatic logic [DW-1:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h7F;
      2: return 8'h80;
      3: return 8'hFF;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++;
    if (d_out !== '0 || flag_out !== '0) begin
      n_fail++; $display("FAIL reset_data: got d=%h f=%b expected zeros", d_out, flag_out);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef CONV_VSUB_STATS_EN
    n_tests++;
    if (sat_cnt_out !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", sat_cnt_out); end
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    exp_q.delete();
  endtask

  logic [1:0]    dv_mode [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
  logic [DW-1:0] dv_a    [7] = '{8'h05, 8'h05, 8'h07, 8'h80, 8'h7F, 8'h10, 8'h03};
  logic [DW-1:0] dv_b    [7] = '{8'h07, 8'h07, 8'h05, 8'h01, 8'hFF, 8'h20, 8'h0A};
  logic [DW-1:0] dv_d    [7] = '{8'hFE, 8'h00, 8'h02, 8'h80, 8'h7F, 8'hF0, 8'h07};
  logic          dv_f    [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic test_directed();
    beat_t e;
    for (int v = 0; v < 7; v++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      mode_in   = dv_mode[v];
      a_in      = {24'($urandom), dv_a[v]};
      b_in      = {24'($urandom), dv_b[v]};
      e = model(mode_in, a_in, b_in);
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_accept: got in_ready=%b expected 1", v, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early: got out_valid=%b expected 0", v, out_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || d_out[DW-1:0] !== dv_d[v] || flag_out[0] !== dv_f[v]) begin
        n_fail++;
        $display("FAIL dir%0d_lane0: got v=%b d=%h f=%b expected v=1 d=%h f=%b", v, out_valid, d_out[DW-1:0], flag_out[0], dv_d[v], dv_f[v]);
      end
      n_tests++;
      if (d_out !== e.d || flag_out !== e.f) begin
        n_fail++; $display("FAIL dir%0d_beat: got d=%h f=%b expected d=%h f=%b", v, d_out, flag_out, e.d, e.f);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_drain: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    beat_t e;
    int got;
    got = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = (c < 12);
      mode_in   = 2'($urandom);
      a_in      = $urandom;
      b_in      = $urandom;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== (c >= 2 && c < 14)) begin
        n_fail++; $display("FAIL b2b_c%0d: got in_ready=%b out_valid=%b expected 1/%b", c, in_ready, out_valid, (c >= 2 && c < 14));
      end
      if (in_valid && in_ready) exp_q.push_back(model(mode_in, a_in, b_in));
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        got++;
        n_tests++;
        if (d_out !== e.d || flag_out !== e.f) begin
          n_fail++; $display("FAIL b2b_data: got d=%h f=%b expected d=%h f=%b", d_out, flag_out, e.d, e.f);
        end
      end
    end
    n_tests++;
    if (got !== 12) begin n_fail++; $display("FAIL b2b_count: got %0d expected 12", got); end
    in_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [LN*DW-1:0] ba [8];
    logic [LN*DW-1:0] bb [8];
    beat_t e;
    int sent, got;
    sent = 0;
    got  = 0;
    for (int i = 0; i < 8; i++) begin ba[i] = $urandom; bb[i] = $urandom; end
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(posedge clk); #1;
      out_ready = (c >= 5);
      in_valid  = (sent < 8);
      mode_in   = 2'd3;
      a_in      = ba[sent & 7];
      b_in      = bb[sent & 7];
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        n_tests++;
        if (in_ready !== 1'b0 || sent !== 2) begin
          n_fail++; $display("FAIL bp_stall_c%0d: got in_ready=%b sent=%0d expected 0/2", c, in_ready, sent);
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(model(mode_in, a_in, b_in)); sent++; end
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        n_tests++;
        if (exp_q.size() == 0 || d_out !== e.d || flag_out !== e.f) begin
          n_fail++; $display("FAIL bp_data%0d: got d=%h f=%b expected d=%h f=%b", got, d_out, flag_out, e.d, e.f);
        end
        if (out_ready) begin void'(exp_q.pop_front()); got++; end
      end
    end
    n_tests++;
    if (got !== 8 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_count: got %0d left %0d expected 8/0", got, exp_q.size());
    end
    in_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_random();
    beat_t e;
    int errs;
    errs = 0;
    for (int c = 0; c < 420; c++) begin
      @(posedge clk); #1;
      in_valid  = (c < 400) && ($urandom_range(0, 9) < 7);
      out_ready = (c >= 400) || ($urandom_range(0, 9) < 6);
      mode_in   = 2'($urandom);
      for (int i = 0; i < LN; i++) begin
        a_in[i*DW +: DW] = pick_val();
        b_in[i*DW +: DW] = pick_val();
      end
      @(negedge clk);
      n_tests++;
      if (in_ready !== ((exp_q.size() < 2) || out_ready)) begin
        n_fail++; $display("FAIL rnd_in_ready_c%0d: got %b with %0d held", c, in_ready, exp_q.size());
      end
      if (in_valid && in_ready) exp_q.push_back(model(mode_in, a_in, b_in));
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra: got d=%h with no beat expected", d_out);
        end else begin
          e = exp_q.pop_front();
          if (d_out !== e.d || flag_out !== e.f) begin
            n_fail++; $display("FAIL rnd_data_c%0d: got d=%h f=%b expected d=%h f=%b", c, d_out, flag_out, e.d, e.f);
          end
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d beats left expected 0", exp_q.size()); end
    in_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      mode_in   = 2'd0;
      a_in      = 32'h0505_0505;
      b_in      = 32'h0707_0707;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || d_out !== '0 || flag_out !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL arst_async: got v=%b d=%h f=%b rdy=%b expected 0/0/0/1", out_valid, d_out, flag_out, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL arst_lost_c%0d: got v=%b rdy=%b expected 0/1", c, out_valid, in_ready);
      end
    end
    exp_q.delete();
  endtask

`ifdef CONV_VSUB_STATS_EN
  task automatic test_stats();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = (c < 5);
      mode_in   = 2'd0;
      a_in      = (c < 3) ? 32'h0000_0005 : 32'h1234_5678;
      b_in      = (c < 3) ? 32'h0000_0007 : 32'h1234_5678;
    end
    @(negedge clk);
    n_tests++;
    if (sat_cnt_out !== 16'd3) begin n_fail++; $display("FAIL stats_count: got %0d expected 3", sat_cnt_out); end
    @(posedge clk); #1;
    stats_clr_in = 1'b1;
    @(posedge clk); #1;
    stats_clr_in = 1'b0;
    @(negedge clk);
    n_tests++;
    if (sat_cnt_out !== '0) begin n_fail++; $display("FAIL stats_clear: got %0d expected 0", sat_cnt_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_async_reset();
`ifdef CONV_VSUB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
